ijtag_scan_driver: RTL and testbench
====================================

# ijtag_scan_driver

Initiator side of the IJTAG network. The block converts a parallel scan request into a correctly sequenced capture/shift/update scan on the IJTAG signals (sel, ce, se, ue, si). It samples the returning scan-out stream and hands the result back through a valid/ready response. It sits between the memory BIST assembly's access logic (or a bench/processor port) and the first SIB or TDR of the memory-test IJTAG network.

## Interface
- DATA_W, 64: maximum scan length in bits; also the width of the request and response data.
- LEN_W, 7: width of req_len; must satisfy 2^LEN_W > DATA_W.

Ports:
- ijtag_tck  in  1  scan clock; all control logic runs on its falling edge.
- ijtag_reset  in  1  reset ijtag_reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request.
- req_len  in  LEN_W  number of shift cycles; 0 means no shift phase.
- req_data  in  DATA_W  scan-in data; bit 0 is shifted first.
- req_capture  in  1  perform a capture phase before shifting.
- req_update  in  1  perform an update phase after shifting.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  scan-out data; bit i is the i-th bit received; bits ≥ effective length are 0.
- ijtag_sel  out  1  network select.
- ijtag_ce  out  1  capture enable.
- ijtag_se  out  1  shift enable.
- ijtag_ue  out  1  update enable.
- ijtag_si  out  1  scan data to network.
- ijtag_so  in  1  scan data from network.

## Operation
- **States:** IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- **IDLE:**
  - req_ready=1.
  - On a falling edge with req_valid=1, the block latches len, data and flags.
  - len_eff = min(req_len, DATA_W).
  - Next state is the first enabled phase, in the order CAPTURE → SHIFT (if len_eff>0) → UPDATE → DONE.
- **CAPTURE:**
  - Lasts 1 period.
  - sel=1, ce=1.
- **SHIFT:**
  - Lasts exactly len_eff periods.
  - sel=1, se=1.
  - ijtag_si = tx[0]; tx shifts right by one at each falling edge.
  - A bit counter runs from 0 to len_eff-1.
- **UPDATE:**
  - Lasts 1 period.
  - sel=1, ue=1.
- **DONE:**
  - rsp_valid=1 and rsp_data is stable.
  - The block stays in DONE while rsp_ready=0.
  - On a falling edge with rsp_ready=1, it returns to IDLE.
- **Outputs outside active phases:**
  - Outside CAPTURE, SHIFT and UPDATE, sel, ce, se, ue and si are all 0.
  - At most one of ce, se and ue is 1 at any time.
- **Scan-out sampling:**
  - ijtag_so is sampled on the rising edge inside each SHIFT period.
  - Sample k is written to rsp_data[k].
  - rsp_data is cleared when a request is accepted.
- **Phase sequencing:**
  - Phases run back-to-back, with no idle period between them.
  - There is at least one idle period between scans, because of the DONE→IDLE transition.
- **Reset:**
  - Asynchronous; takes effect at any point, including mid-scan.
  - The FSM goes to IDLE.
  - All ijtag_* outputs are 0, rsp_valid=0, rsp_data=0, req_ready=1.
  - A partially shifted scan is discarded; no update is issued.

## Timing
- **Output registration:**
  - All outputs are registered on the falling edge of ijtag_tck.
  - ce and se are therefore stable at the responder's rising-edge sampling point.
  - ue is held for a full period, so it spans the responder's next falling edge.
- **Acceptance:** a request is accepted at falling edge n, and the first phase is driven from edge n.
- **Scan latency:** total periods from acceptance to rsp_valid = c + len_eff + u, where c = req_capture and u = req_update.
  - rsp_valid rises at falling edge n + c + len_eff + u.
- **Degenerate request:** with len_eff=0 and no capture or update, the block goes IDLE → DONE in 1 period; rsp_data=0.
- **Scan-out timing:** the first sampled bit is the value on ijtag_so during the first SHIFT period. The network's retimed scan-out is stable from the preceding falling edge.

## Test plan
- **Reset:**
  - Stimulus: assert ijtag_reset=0 with random inputs.
  - Required: all ijtag_* outputs = 0, rsp_valid=0, req_ready=1. These values hold through 3 tck periods after release with req_valid=0.
- **Full scan:**
  - Stimulus: len=8, data=0xA5, capture=1, update=1, against an 8-bit TDR model whose capture value is 0x3C.
  - Required: rsp_data=0x3C and the model update register = 0xA5.
  - Required: ce high for 1 period, se for exactly 8, ue for 1; rsp_valid arrives 10 periods after acceptance.
- **Zero length:**
  - Stimulus: len=0, capture=1, update=1.
  - Required: se never asserted, ue high for 1 period, rsp_data=0, rsp_valid 2 periods after acceptance.
- **Length clamp:**
  - Stimulus: len=64 with data=0xDEADBEEF_0123ABCD through a 64-bit loopback TDR. Then repeat with len=100.
  - Required: both runs give exactly 64 se periods and rsp_data equals the previously updated value.
- **Backpressure:**
  - Stimulus: hold rsp_ready=0 for 5 periods in DONE while req_valid=1.
  - Required: rsp_valid and rsp_data stable, req_ready=0, no ijtag activity. The next request is accepted only after the DONE→IDLE transition.
- **Reset mid-shift:**
  - Stimulus: assert reset after 3 of 8 shift bits.
  - Required: outputs go to 0 immediately and the model update register is unchanged.
  - Required: after release, a new len=8 request completes correctly.

Source files
------------

// File: rtl/ijtag_scan_driver.sv
// IJTAG initiator: turns a parallel scan request into a capture/shift/update
// sequence on the IJTAG signals and returns the sampled scan-out as a response.
module ijtag_scan_driver #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 7
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_capture,
  input  logic              req_update,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ijtag_sel,
  output logic              ijtag_ce,
  output logic              ijtag_se,
  output logic              ijtag_ue,
  output logic              ijtag_si,
  input  logic              ijtag_so
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_r;
  state_t            nxt_s;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [LEN_W-1:0]  len_in_s;
  logic [LEN_W-1:0]  len_s;
  logic              upd_r;
  logic              upd_s;
  logic              accept_s;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] tx_s;
  logic              so_r;

  function automatic state_t after_shift(input logic upd);
    if (upd) begin
      return UPDATE;
    end else begin
      return DONE;
    end
  endfunction

  // Clamp the requested length and select live request fields while idle.
  always_comb begin
    len_in_s = (req_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : req_len;
    accept_s = (state_r == IDLE) && req_valid;
    len_s    = (state_r == IDLE) ? len_in_s   : len_r;
    upd_s    = (state_r == IDLE) ? req_update : upd_r;
    tx_s     = (state_r == IDLE) ? req_data   : tx_r;
  end

  // Next-state decode; phases chain back-to-back, skipping disabled ones.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          nxt_s = IDLE;
        end else if (req_capture) begin
          nxt_s = CAPTURE;
        end else if (len_s != {LEN_W{1'b0}}) begin
          nxt_s = SHIFT;
        end else begin
          nxt_s = after_shift(upd_s);
        end
      end
      CAPTURE: begin
        if (len_s != {LEN_W{1'b0}}) begin
          nxt_s = SHIFT;
        end else begin
          nxt_s = after_shift(upd_s);
        end
      end
      SHIFT: begin
        if (cnt_r == (len_s - LEN_W'(1))) begin
          nxt_s = after_shift(upd_s);
        end else begin
          nxt_s = SHIFT;
        end
      end
      UPDATE:  nxt_s = DONE;
      DONE:    nxt_s = rsp_ready ? IDLE : DONE;
      default: nxt_s = IDLE;
    endcase
  end

  // Scan-out is stable from the previous falling edge; grab it mid-period.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      so_r <= 1'b0;
    end else begin
      so_r <= ijtag_so;
    end
  end

  // FSM state, datapath and registered outputs decoded from the next state.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_r   <= IDLE;
      len_r     <= {LEN_W{1'b0}};
      upd_r     <= 1'b0;
      cnt_r     <= {LEN_W{1'b0}};
      tx_r      <= {DATA_W{1'b0}};
      rsp_data  <= {DATA_W{1'b0}};
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ijtag_sel <= 1'b0;
      ijtag_ce  <= 1'b0;
      ijtag_se  <= 1'b0;
      ijtag_ue  <= 1'b0;
      ijtag_si  <= 1'b0;
    end else begin
      state_r <= nxt_s;
      if (accept_s) begin
        len_r    <= len_in_s;
        upd_r    <= req_update;
        cnt_r    <= {LEN_W{1'b0}};
        rsp_data <= {DATA_W{1'b0}};
      end else if (state_r == SHIFT) begin
        cnt_r                        <= cnt_r + LEN_W'(1);
        rsp_data[cnt_r[IDX_W-1:0]]   <= so_r;
      end
      tx_r      <= (nxt_s == SHIFT) ? (tx_s >> 1) : tx_s;
      ijtag_si  <= (nxt_s == SHIFT) ? tx_s[0] : 1'b0;
      ijtag_sel <= (nxt_s == CAPTURE) || (nxt_s == SHIFT) || (nxt_s == UPDATE);
      ijtag_ce  <= (nxt_s == CAPTURE);
      ijtag_se  <= (nxt_s == SHIFT);
      ijtag_ue  <= (nxt_s == UPDATE);
      rsp_valid <= (nxt_s == DONE);
      req_ready <= (nxt_s == IDLE);
    end
  end

endmodule

// File: tb/tb_ijtag_scan_driver.sv
// Self-checking bench for ijtag_scan_driver with an 8/64-bit TDR model on the
// IJTAG side and a response scoreboard.
module tb_ijtag_scan_driver;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 7;

  logic              ijtag_tck = 1'b0;
  logic              ijtag_reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              req_capture = 1'b0;
  logic              req_update = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic              ijtag_so;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  // TDR model: 8-bit (capture 0x3C) or 64-bit loopback (capture = update reg)
  logic        mode64 = 1'b0;
  logic [63:0] sr = '0;
  logic [63:0] upd64 = '0;
  logic [7:0]  upd8 = '0;
  logic        so_m = 1'b0;
  int ce_cnt = 0, se_cnt = 0, ue_cnt = 0, multi_cnt = 0;

  assign ijtag_so = so_m;

  ijtag_scan_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_data(req_data), .req_capture(req_capture), .req_update(req_update),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ijtag_sel(ijtag_sel), .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se),
    .ijtag_ue(ijtag_ue), .ijtag_si(ijtag_si), .ijtag_so(ijtag_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  always @(posedge ijtag_tck) begin
    if (ijtag_sel && ijtag_ce) sr <= mode64 ? upd64 : 64'h3C;
    else if (ijtag_sel && ijtag_se)
      sr <= mode64 ? {ijtag_si, sr[63:1]} : {56'h0, ijtag_si, sr[7:1]};
    ce_cnt <= ce_cnt + int'(ijtag_sel && ijtag_ce);
    se_cnt <= se_cnt + int'(ijtag_sel && ijtag_se);
    ue_cnt <= ue_cnt + int'(ijtag_sel && ijtag_ue);
    multi_cnt <= multi_cnt + int'((32'(ijtag_ce) + 32'(ijtag_se) + 32'(ijtag_ue)) > 1);
  end

  always @(negedge ijtag_tck) begin
    so_m <= sr[0];
    if (ijtag_sel && ijtag_ue) begin
      if (mode64) upd64 <= sr;
      else upd8 <= sr[7:0];
    end
  end

  task automatic issue(input logic [6:0] len, input logic [63:0] data,
                       input logic cap, input logic upd, input logic [63:0] exp);
    @(posedge ijtag_tck); #1;
    req_len = len; req_data = data; req_capture = cap; req_update = upd;
    req_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge ijtag_tck); #1;
    req_valid = 1'b0;
    ce_cnt = 0; se_cnt = 0; ue_cnt = 0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    @(posedge ijtag_tck);
    while (rsp_valid !== 1'b1 && k < 300) begin
      @(posedge ijtag_tck);
      k++;
    end
  endtask

  task automatic consume();
    #1 rsp_ready = 1'b1;
    @(negedge ijtag_tck); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    ijtag_reset = 1'b0;
    req_valid = 1'($urandom); req_capture = 1'($urandom); req_update = 1'($urandom);
    req_len = 7'($urandom); req_data = {$urandom, $urandom}; rsp_ready = 1'($urandom);
    #12;
    total++;
    if ({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready} !== 7'b0000001
        || rsp_data !== 64'h0) begin
      bad++; $display("FAIL reset_state: outs=%b rsp=%h required 0000001/0",
        {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready}, rsp_data);
    end
    @(posedge ijtag_tck); #1;
    req_valid = 1'b0; rsp_ready = 1'b0; ijtag_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ijtag_tck); #1;
      total++;
      if ({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready} !== 7'b0000001) begin
        bad++; $display("FAIL reset_hold[%0d]: outs=%b required 0000001", i,
          {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready});
      end
    end
  endtask

  task automatic test_full_scan();
    int k;
    logic [63:0] e;
    mode64 = 1'b0;
    issue(7'd8, 64'hA5, 1'b1, 1'b1, 64'h3C);
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e) begin bad++; $display("FAIL full_rsp: got %h required %h", rsp_data, e); end
    total++;
    if (k !== 10) begin bad++; $display("FAIL full_latency: got %0d required 10", k); end
    total++;
    if (upd8 !== 8'hA5) begin bad++; $display("FAIL full_update: got %h required a5", upd8); end
    total++;
    if (ce_cnt !== 1 || se_cnt !== 8 || ue_cnt !== 1) begin
      bad++; $display("FAIL full_phases: ce=%0d se=%0d ue=%0d required 1/8/1", ce_cnt, se_cnt, ue_cnt);
    end
    consume();
  endtask

  task automatic test_zero_length();
    int k;
    logic [63:0] e;
    issue(7'd0, 64'hFF, 1'b1, 1'b1, 64'h0);
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e || k !== 2 || se_cnt !== 0 || ue_cnt !== 1 || ce_cnt !== 1) begin
      bad++; $display("FAIL zero_len: rsp=%h lat=%0d se=%0d ue=%0d ce=%0d required 0/2/0/1/1",
        rsp_data, k, se_cnt, ue_cnt, ce_cnt);
    end
    consume();
    issue(7'd0, 64'h1234, 1'b0, 1'b0, 64'h0);
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e || k !== 0 || (ce_cnt + se_cnt + ue_cnt) !== 0) begin
      bad++; $display("FAIL degenerate: rsp=%h lat=%0d phases=%0d required 0/0/0",
        rsp_data, k, ce_cnt + se_cnt + ue_cnt);
    end
    consume();
  endtask

  task automatic test_length_clamp();
    int k;
    logic [63:0] e;
    logic [6:0] lens [3] = '{7'd64, 7'd64, 7'd100};
    logic [63:0] dat [3] = '{64'h0F1E2D3C4B5A6978, 64'hDEADBEEF0123ABCD, 64'h2152411_0FEDC5432};
    mode64 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(lens[i], dat[i], 1'b1, 1'b1, upd64);
      wait_valid(k);
      e = exp_q.pop_front();
      total++;
      if (rsp_data !== e || upd64 !== dat[i]) begin
        bad++; $display("FAIL clamp_data[%0d]: rsp=%h upd=%h required %h/%h", i, rsp_data, upd64, e, dat[i]);
      end
      total++;
      if (se_cnt !== 64 || k !== 66) begin
        bad++; $display("FAIL clamp_len[%0d]: se=%0d lat=%0d required 64/66", i, se_cnt, k);
      end
      consume();
    end
    mode64 = 1'b0;
  endtask

  task automatic test_backpressure();
    int k;
    logic [63:0] e;
    logic [63:0] held;
    issue(7'd8, 64'h11, 1'b1, 1'b1, 64'h3C);
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e) begin bad++; $display("FAIL bp_rsp: got %h required %h", rsp_data, e); end
    held = e;
    #1;
    req_len = 7'd4; req_data = 64'h77; req_capture = 1'b1; req_update = 1'b0; req_valid = 1'b1;
    exp_q.push_back(64'hC);
    for (int i = 0; i < 5; i++) begin
      @(posedge ijtag_tck);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0
          || {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si} !== 5'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: v=%b rsp=%h rdy=%b ijtag=%b required 1/%h/0/00000", i,
          rsp_valid, rsp_data, req_ready, {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, held);
      end
    end
    consume();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ijtag_sel !== 1'b0) begin
      bad++; $display("FAIL bp_idle: rdy=%b v=%b sel=%b required 1/0/0", req_ready, rsp_valid, ijtag_sel);
    end
    @(negedge ijtag_tck); #1;
    req_valid = 1'b0;
    ce_cnt = 0; se_cnt = 0; ue_cnt = 0;
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e || k !== 5 || se_cnt !== 4 || upd8 !== 8'h11) begin
      bad++; $display("FAIL bp_next: rsp=%h lat=%0d se=%0d upd=%h required %h/5/4/11",
        rsp_data, k, se_cnt, upd8, e);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int k;
    logic [63:0] e;
    logic [7:0] prev;
    prev = upd8;
    issue(7'd8, 64'h5A, 1'b1, 1'b1, 64'h3C);
    repeat (4) @(posedge ijtag_tck);
    #2 ijtag_reset = 1'b0;
    #1;
    total++;
    if ({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready} !== 7'b0000001
        || rsp_data !== 64'h0 || se_cnt !== 3) begin
      bad++; $display("FAIL midrst_outs: outs=%b rsp=%h se=%0d required 0000001/0/3",
        {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, req_ready}, rsp_data, se_cnt);
    end
    void'(exp_q.pop_front());
    repeat (3) @(negedge ijtag_tck);
    total++;
    if (upd8 !== prev) begin bad++; $display("FAIL midrst_upd: got %h required %h", upd8, prev); end
    @(posedge ijtag_tck); #1 ijtag_reset = 1'b1;
    issue(7'd8, 64'h96, 1'b1, 1'b1, 64'h3C);
    wait_valid(k);
    e = exp_q.pop_front();
    total++;
    if (rsp_data !== e || k !== 10 || upd8 !== 8'h96 || se_cnt !== 8) begin
      bad++; $display("FAIL midrst_after: rsp=%h lat=%0d upd=%h se=%0d required %h/10/96/8",
        rsp_data, k, upd8, se_cnt, e);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_zero_length();
    test_length_clamp();
    test_backpressure();
    test_reset_mid_shift();
    total++;
    if (multi_cnt !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL exclusivity: overlaps=%0d left=%0d required 0/0", multi_cnt, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
